// File: rtl/sram_seq_initiator.sv
// Bulk-sequence initiator for a single-port byte-enable SRAM with 1-cycle
// registered read data. One command runs a pattern fill, a read-back verify
// or a read checksum over a contiguous, word-aligned, wrapping address range.
module sram_seq_initiator #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-2:0] word_count_i,
  input  logic [31:0]           seed_i,
  input  logic                  incr_i,
  input  logic [3:0]            be_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [15:0]           err_count_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o,
  output logic [31:0]           checksum_o,
  output logic                  mem_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  input  logic [31:0]           mem_rdata_i
);

  localparam logic [1:0] OP_FILL     = 2'b00;
  localparam logic [1:0] OP_VERIFY   = 2'b01;
  localparam logic [1:0] OP_CHECKSUM = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Expand a 4-bit byte enable into a 32-bit bit mask.
  function automatic logic [31:0] expand_be(input logic [3:0] be);
    expand_be = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  state_t                state_r;
  logic [1:0]            op_r;
  logic [3:0]            be_r;
  logic                  incr_r;
  logic [ADDR_WIDTH-2:0] n_r;
  logic [ADDR_WIDTH-2:0] cnt_r;       // index of the access currently on the bus
  logic [ADDR_WIDTH-1:0] addr_r;      // address of the access currently on the bus
  logic [31:0]           pat_r;       // pattern of the access currently on the bus
  logic                  rd_valid_r;  // a read return is arriving this cycle
  logic [ADDR_WIDTH-1:0] rd_addr_r;
  logic [31:0]           rd_pat_r;

  logic [ADDR_WIDTH-1:0] base_word_s;
  logic [ADDR_WIDTH-1:0] next_addr_s;
  logic [31:0]           next_pat_s;
  logic [31:0]           diff_s;
  logic                  mismatch_s;
  logic                  last_s;
  logic                  legal_s;
  logic                  is_fill_s;

  // Next-access address/pattern and read-return compare.
  always_comb begin
    base_word_s = base_addr_i & ~ADDR_WIDTH'(2'b11);
    next_addr_s = addr_r + ADDR_WIDTH'(3'd4);
    next_pat_s  = incr_r ? (pat_r + 32'd1) : pat_r;
    diff_s      = (mem_rdata_i ^ rd_pat_r) & expand_be(be_r);
    mismatch_s  = rd_valid_r && (op_r == OP_VERIFY) && (diff_s != 32'd0);
    last_s      = (cnt_r == (n_r - (ADDR_WIDTH-1)'(1'b1)));
    legal_s     = (op_i == OP_FILL) || (op_i == OP_VERIFY) || (op_i == OP_CHECKSUM);
    is_fill_s   = (op_i == OP_FILL);
  end

  // Sequencer FSM, read-return accumulation and all registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r          <= ST_IDLE;
      op_r             <= 2'b00;
      be_r             <= 4'b0000;
      incr_r           <= 1'b0;
      n_r              <= '0;
      cnt_r            <= '0;
      addr_r           <= '0;
      pat_r            <= 32'd0;
      rd_valid_r       <= 1'b0;
      rd_addr_r        <= '0;
      rd_pat_r         <= 32'd0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      err_o            <= 1'b0;
      err_count_o      <= 16'd0;
      first_err_addr_o <= '0;
      checksum_o       <= 32'd0;
      mem_en_o         <= 1'b0;
      mem_addr_o       <= '0;
      mem_wdata_o      <= 32'd0;
      mem_we_o         <= 1'b0;
      mem_be_o         <= 4'b0000;
    end else begin
      rd_valid_r <= 1'b0;
      if (rd_valid_r) begin
        checksum_o <= checksum_o + mem_rdata_i;
        if (mismatch_s) begin
          err_o <= 1'b1;
          if (err_count_o != 16'hFFFF) begin
            err_count_o <= err_count_o + 16'd1;
          end
          if (err_count_o == 16'd0) begin
            first_err_addr_o <= rd_addr_r;
          end
        end
      end

      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            op_r             <= op_i;
            be_r             <= be_i;
            incr_r           <= incr_i;
            n_r              <= word_count_i;
            cnt_r            <= '0;
            addr_r           <= base_word_s;
            pat_r            <= seed_i;
            busy_o           <= 1'b1;
            err_o            <= ~legal_s;
            err_count_o      <= 16'd0;
            first_err_addr_o <= '0;
            checksum_o       <= 32'd0;
            if (legal_s && (word_count_i != '0)) begin
              state_r     <= ST_ISSUE;
              mem_en_o    <= 1'b1;
              mem_addr_o  <= base_word_s;
              mem_we_o    <= is_fill_s;
              mem_be_o    <= is_fill_s ? be_i : 4'b0000;
              mem_wdata_o <= is_fill_s ? seed_i : 32'd0;
            end else begin
              state_r <= ST_DONE;
              done_o  <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          rd_valid_r <= (op_r != OP_FILL);
          rd_addr_r  <= addr_r;
          rd_pat_r   <= pat_r;
          if (last_s) begin
            mem_en_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= 4'b0000;
            mem_wdata_o <= 32'd0;
            if (op_r == OP_FILL) begin
              state_r <= ST_DONE;
              done_o  <= 1'b1;
            end else begin
              state_r <= ST_DRAIN;
            end
          end else begin
            cnt_r       <= cnt_r + (ADDR_WIDTH-1)'(1'b1);
            addr_r      <= next_addr_s;
            pat_r       <= next_pat_s;
            mem_addr_o  <= next_addr_s;
            mem_wdata_o <= (op_r == OP_FILL) ? next_pat_s : 32'd0;
          end
        end
        ST_DRAIN: begin
          state_r <= ST_DONE;
          done_o  <= 1'b1;
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_o  <= 1'b0;
          busy_o  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          done_o  <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_seq_initiator.sv
// Directed bench for sram_seq_initiator with a behavioural byte-enable SRAM.
module tb_sram_seq_initiator;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [1:0]    op_i;
  logic [AW-1:0] base_addr_i;
  logic [AW-2:0] word_count_i;
  logic [31:0]   seed_i;
  logic          incr_i;
  logic [3:0]    be_i;
  logic          busy_o, done_o, err_o;
  logic [15:0]   err_count_o;
  logic [AW-1:0] first_err_addr_o;
  logic [31:0]   checksum_o;
  logic          mem_en_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [3:0]    mem_be_o;
  logic [31:0]   mem_rdata_i;

  // SRAM model plus bench-side poke/clear port
  logic [31:0]   mem [0:1023];
  logic          mem_clr;
  logic          poke_en;
  logic [9:0]    poke_idx;
  logic [31:0]   poke_val;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_seq_initiator #(.ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .base_addr_i(base_addr_i), .word_count_i(word_count_i), .seed_i(seed_i),
    .incr_i(incr_i), .be_i(be_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .err_count_o(err_count_o), .first_err_addr_o(first_err_addr_o),
    .checksum_o(checksum_o), .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_rdata_i(mem_rdata_i)
  );

  // Single-port SRAM with byte-enable writes and registered read data
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
    end else if (poke_en) begin
      mem[poke_idx] <= poke_val;
    end else if (mem_en_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) mem[mem_addr_o[11:2]][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
      end else begin
        mem_rdata_i <= mem[mem_addr_o[11:2]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic [1:0] op, input logic [AW-1:0] base,
                           input logic [AW-2:0] n, input logic [31:0] seed,
                           input logic incr, input logic [3:0] be);
    op_i = op; base_addr_i = base; word_count_i = n;
    seed_i = seed; incr_i = incr; be_i = be;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic chk_bus(input string tag, input logic en, input logic we,
                         input logic [AW-1:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be);
    chk({tag, "_en"}, 32'(mem_en_o), 32'(en));
    chk({tag, "_we"}, 32'(mem_we_o), 32'(we));
    chk({tag, "_addr"}, 32'(mem_addr_o), 32'(addr));
    chk({tag, "_wdata"}, mem_wdata_o, wdata);
    chk({tag, "_be"}, 32'(mem_be_o), 32'(be));
  endtask

  // From T+1, expect done_o first at T+lat; leaves the bench in the done cycle.
  task automatic wait_done(input string tag, input int lat);
    for (int i = 1; i < lat; i++) begin
      chk({tag, "_notdone"}, 32'(done_o), 32'd0);
      chk({tag, "_busy"}, 32'(busy_o), 32'd1);
      step();
    end
    chk({tag, "_done"}, 32'(done_o), 32'd1);
    chk({tag, "_busy_done"}, 32'(busy_o), 32'd1);
  endtask

  task automatic chk_results(input string tag, input logic err, input logic [15:0] cnt,
                             input logic [AW-1:0] faddr, input logic [31:0] sum);
    chk({tag, "_err"}, 32'(err_o), 32'(err));
    chk({tag, "_cnt"}, 32'(err_count_o), 32'(cnt));
    chk({tag, "_faddr"}, 32'(first_err_addr_o), 32'(faddr));
    chk({tag, "_sum"}, checksum_o, sum);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; op_i = 2'b00; base_addr_i = '0; word_count_i = '0;
    seed_i = 32'd0; incr_i = 1'b0; be_i = 4'b0000;
    mem_clr = 1'b1; poke_en = 1'b0; poke_idx = 10'd0; poke_val = 32'd0;
    step(); step();
    mem_clr = 1'b0;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk_results("rst", 1'b0, 16'd0, 12'h000, 32'd0);
    chk_bus("rst_bus", 1'b0, 1'b0, 12'h000, 32'd0, 4'b0000);
    rst_i = 1'b0;
    step();

    // Fill 0x100 x4, incrementing; a start during busy and one in the done cycle are ignored
    start_cmd(2'b00, 12'h100, 11'd4, 32'hA5A50000, 1'b1, 4'b1111);
    for (int k = 0; k < 4; k++) begin
      chk_bus("fill1", 1'b1, 1'b1, 12'(12'h100 + 4*k), 32'hA5A50000 + 32'(k), 4'b1111);
      chk("fill1_busy", 32'(busy_o), 32'd1);
      if (k == 1) begin
        op_i = 2'b11; base_addr_i = 12'h800; word_count_i = 11'd9; seed_i = 32'd7;
        start_i = 1'b1;
      end else begin
        start_i = 1'b0;
      end
      step();
    end
    chk("fill1_done", 32'(done_o), 32'd1);
    chk("fill1_err", 32'(err_o), 32'd0);
    chk_bus("fill1_after", 1'b0, 1'b0, 12'h000, 32'd0, 4'b0000);
    op_i = 2'b10; word_count_i = 11'd4; start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("donecyc_start_ignored", 32'(busy_o), 32'd0);
    chk("fill1_done_pulse", 32'(done_o), 32'd0);
    chk("fill1_mem0", mem[10'h40], 32'hA5A50000);
    chk("fill1_mem3", mem[10'h43], 32'hA5A50003);
    chk("fill1_mem4", mem[10'h44], 32'h00000000);

    // Verify clean range
    start_cmd(2'b01, 12'h100, 11'd4, 32'hA5A50000, 1'b1, 4'b1111);
    chk_bus("ver1_k0", 1'b1, 1'b0, 12'h100, 32'd0, 4'b0000);
    wait_done("ver1", 6);
    chk_results("ver1", 1'b0, 16'd0, 12'h000, 32'h96940006);
    step();

    // Corrupt byte 1 of word 0x108
    poke_idx = 10'h42; poke_val = 32'hA5A5FF02; poke_en = 1'b1; step(); poke_en = 1'b0;
    start_cmd(2'b01, 12'h100, 11'd4, 32'hA5A50000, 1'b1, 4'b1111);
    wait_done("ver2", 6);
    chk_results("ver2", 1'b1, 16'd1, 12'h108, 32'h9694FF06);
    step();
    start_cmd(2'b01, 12'h100, 11'd4, 32'hA5A50000, 1'b1, 4'b1101);
    wait_done("ver3", 6);
    chk_results("ver3", 1'b0, 16'd0, 12'h000, 32'h9694FF06);
    step();

    // Second corruption: first_err_addr must stay at the first mismatch
    poke_idx = 10'h43; poke_val = 32'hA5A500FF; poke_en = 1'b1; step(); poke_en = 1'b0;
    start_cmd(2'b01, 12'h102, 11'd4, 32'hA5A50000, 1'b1, 4'b1111);
    chk_bus("ver4_k0", 1'b1, 1'b0, 12'h100, 32'd0, 4'b0000);
    wait_done("ver4", 6);
    chk_results("ver4", 1'b1, 16'd2, 12'h108, 32'h96950002);
    step();

    // Wrapping constant fill at 0xFF8, then checksum
    start_cmd(2'b00, 12'hFF8, 11'd4, 32'hDEADBEEF, 1'b0, 4'b1111);
    chk_bus("wrap_k0", 1'b1, 1'b1, 12'hFF8, 32'hDEADBEEF, 4'b1111); step();
    chk_bus("wrap_k1", 1'b1, 1'b1, 12'hFFC, 32'hDEADBEEF, 4'b1111); step();
    chk_bus("wrap_k2", 1'b1, 1'b1, 12'h000, 32'hDEADBEEF, 4'b1111); step();
    chk_bus("wrap_k3", 1'b1, 1'b1, 12'h004, 32'hDEADBEEF, 4'b1111); step();
    chk("wrap_done", 32'(done_o), 32'd1);
    step();
    start_cmd(2'b10, 12'hFF8, 11'd4, 32'h00000000, 1'b0, 4'b0000);
    chk_bus("csum_k0", 1'b1, 1'b0, 12'hFF8, 32'd0, 4'b0000);
    wait_done("csum", 6);
    chk_results("csum", 1'b0, 16'd0, 12'h000, 32'h7AB6FBBC);
    step();

    // N=0: immediate done, no access, results cleared
    start_cmd(2'b01, 12'h100, 11'd0, 32'hA5A50000, 1'b1, 4'b1111);
    chk("n0_done", 32'(done_o), 32'd1);
    chk_bus("n0_bus", 1'b0, 1'b0, 12'h000, 32'd0, 4'b0000);
    chk_results("n0", 1'b0, 16'd0, 12'h000, 32'd0);
    step();

    // Illegal op
    start_cmd(2'b11, 12'h100, 11'd4, 32'h1, 1'b1, 4'b1111);
    chk("ill_done", 32'(done_o), 32'd1);
    chk("ill_busy", 32'(busy_o), 32'd1);
    chk_bus("ill_bus", 1'b0, 1'b0, 12'h000, 32'd0, 4'b0000);
    chk_results("ill", 1'b1, 16'd0, 12'h000, 32'd0);
    step();

    // Partial byte-enable fill
    start_cmd(2'b00, 12'h200, 11'd1, 32'h12345678, 1'b0, 4'b0011);
    chk_bus("pbe", 1'b1, 1'b1, 12'h200, 32'h12345678, 4'b0011);
    step();
    chk("pbe_done", 32'(done_o), 32'd1);
    step();
    chk("pbe_mem", mem[10'h80], 32'h00005678);

    // Reset in T+2 of an 8-word fill
    start_cmd(2'b00, 12'h300, 11'd8, 32'h00000001, 1'b1, 4'b1111);
    chk_bus("rstmid_k0", 1'b1, 1'b1, 12'h300, 32'h1, 4'b1111);
    step();
    chk_bus("rstmid_k1", 1'b1, 1'b1, 12'h304, 32'h2, 4'b1111);
    rst_i = 1'b1;
    step();
    chk_bus("rstmid_bus", 1'b0, 1'b0, 12'h000, 32'd0, 4'b0000);
    chk("rstmid_busy", 32'(busy_o), 32'd0);
    chk("rstmid_done", 32'(done_o), 32'd0);
    chk_results("rstmid", 1'b0, 16'd0, 12'h000, 32'd0);
    rst_i = 1'b0;
    step(); step(); step();
    chk("rstmid_idle_en", 32'(mem_en_o), 32'd0);
    chk("rstmid_idle_busy", 32'(busy_o), 32'd0);
    chk("rstmid_w0", mem[10'hC0], 32'h1);
    chk("rstmid_w1", mem[10'hC1], 32'h2);
    chk("rstmid_w2", mem[10'hC2], 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_seq_initiator.md
Name: sram_seq_initiator

Overview:
- Initiator for the testbench single-port byte-enable SRAM port (en/addr/wdata/we/be, rdata registered with 1-cycle latency).
- Executes one bulk sequence per command: pattern fill, read-back verify, or read checksum, over a contiguous word range.
- Used by the core testbench to pre-load, scrub and check memory images without involving the core.

Parameters:
ADDR_WIDTH, 12, width of the SRAM byte address; addresses are word-aligned and wrap modulo 2**ADDR_WIDTH.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  command strobe, sampled only in IDLE
op_i  in  2  00 fill, 01 verify, 10 checksum, 11 illegal
base_addr_i  in  ADDR_WIDTH  start byte address; bits [1:0] ignored (forced 00)
word_count_i  in  ADDR_WIDTH-1  number of words N (0 allowed)
seed_i  in  32  pattern value for word 0
incr_i  in  1  1: pattern for word k = seed+k (mod 2**32); 0: constant seed
be_i  in  4  byte enables for fill writes and verify compare mask
busy_o  out  1  high from cycle after accepted start until done_o cycle inclusive
done_o  out  1  one-cycle completion pulse
err_o  out  1  sticky: mismatch seen or illegal op
err_count_o  out  16  mismatching words, saturates at 16'hFFFF
first_err_addr_o  out  ADDR_WIDTH  byte address of first mismatch
checksum_o  out  32  sum of all read words mod 2**32 (verify and checksum ops)
mem_en_o  out  1  SRAM enable
mem_addr_o  out  ADDR_WIDTH  SRAM byte address
mem_wdata_o  out  32  SRAM write data
mem_we_o  out  1  SRAM write enable
mem_be_o  out  4  SRAM byte enables
mem_rdata_i  in  32  SRAM read data, valid the cycle after a read enable

Behaviour:
- Reset: state IDLE; all outputs 0. Reset mid-sequence aborts immediately, no further mem_en_o, results cleared.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE, start_i=1 at cycle T: latch all command inputs, clear err/err_count/first_err_addr/checksum. Go to ISSUE if N>0 and op legal, else DONE.
- start_i while not IDLE: ignored, no effect on latched command.
- ISSUE: one access per cycle, T+1..T+N; access k uses addr = base + 4k (wraps mod 2**ADDR_WIDTH), expected/pattern p_k = incr ? seed+k : seed.
  - fill: mem_en_o=1, mem_we_o=1, mem_be_o=be, mem_wdata_o=p_k. After last write -> DONE; done_o at T+N+1.
  - verify/checksum: mem_en_o=1, mem_we_o=0, mem_be_o=0, mem_wdata_o=0. After last read -> DRAIN.
- Read return: mem_rdata_i sampled in cycle after each read (T+2..T+N+1), paired with its address and p_k through a 1-deep pipeline register.
  - checksum_o += rdata (both verify and checksum ops).
  - verify only: mismatch if (rdata ^ p_k) masked by byte-expanded be is nonzero; be=0000 never mismatches. On mismatch: err_count++ (saturating), err_o=1, first_err_addr_o set only on first mismatch.
- DRAIN: consumes final return at T+N+1, -> DONE; done_o at T+N+2.
- DONE: done_o=1 for exactly one cycle, busy_o=1 in that cycle, -> IDLE. Results held stable until next accepted start.
- N=0 legal op: no mem access, done_o at T+1, results zero.
- Illegal op 11: no mem access, done_o at T+1, err_o=1, err_count_o=0.
- Outside ISSUE: mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o all 0.
- start_i in the cycle done_o is high is ignored; a new start is accepted from the following IDLE cycle.

Test Plan:
- Fill base=0x100, N=4, seed=0xA5A50000, incr=1, be=1111 -> writes 0xA5A50000..0xA5A50003 at 0x100,0x104,0x108,0x10C in T+1..T+4; done_o at T+5.
- Verify same range/pattern after fill -> err_o=0, err_count_o=0, checksum_o=0x96940006, done_o at T+6.
- Corrupt byte 1 of word at 0x108 then verify with be=1111 -> err_count_o=1, first_err_addr_o=0x108; repeat with be=1101 -> err_o=0.
- Fill base=0xFF8 (ADDR_WIDTH=12), N=4, constant seed=0xDEADBEEF -> addresses 0xFF8,0xFFC,0x000,0x004; checksum over same range = 0x7AB6FBBC.
- N=0 -> done_o at T+1, no mem_en_o; op=11 -> done_o at T+1, err_o=1; start_i pulsed during busy -> ignored, original sequence completes unchanged.
- Assert rst_i at T+2 of an N=8 fill -> mem_en_o=0 from next cycle, busy_o=0, all result outputs 0, only 2 words written.
